// File: rtl/elevator_request_queue.sv
// Elevator call-button front end: synchronizes and debounces four raw call
// buttons, latches pending requests, and runs a small door-dwell FSM that
// clears a floor's request once the car has sat at that floor for the full
// dwell time.

// Per-floor button conditioner: 2-flop synchronizer, then a debouncer that
// adopts the synchronized value only after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles. 'rise' pulses on the edge where the
// debounced level goes 0->1.
module erq_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        s1, s2;
  logic        deb;
  logic [15:0] cnt;
  logic        flip;

  // The debounced level changes on the edge where the disagreement counter
  // has already seen DEBOUNCE_CYCLES-1 mismatching cycles and this is one more.
  assign flip = (s2 != deb) && (cnt == DB_LAST);
  assign rise = flip && s2;

  // Synchronizer, debounce counter and debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (flip) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

module elevator_request_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] floor,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       rd,
  output logic [3:0] pend,
  output logic       door_open,
  output logic       floor_err
);

  localparam int unsigned NUM_FLOORS = 4;
  localparam logic [15:0] DW_LAST    = 16'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                  state;
  logic [NUM_FLOORS-1:0]   rise;
  logic [NUM_FLOORS-1:0]   svc;
  logic [15:0]             dcnt;
  logic                    floor_ok;
  logic [NUM_FLOORS-1:0]   pend_set;

  // One conditioner per floor button.
  erq_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_FLOORS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .rise (rise)
  );

  assign floor_ok = (floor != 4'd0) && ((floor & (floor - 4'd1)) == 4'd0);
  // Press edges always land, whichever state the FSM is in.
  assign pend_set = pend | rise;

  assign ra = pend[0];
  assign rb = pend[1];
  assign rc = pend[2];
  assign rd = pend[3];

  // Request latch and dwell FSM. A press edge on the serviced floor takes
  // priority over expiry so the door is held open instead of closing on a
  // fresh call.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      svc       <= '0;
      dcnt      <= '0;
      door_open <= 1'b0;
      floor_err <= 1'b0;
    end else begin
      if (!floor_ok) floor_err <= 1'b1;
      pend <= pend_set;
      case (state)
        IDLE: begin
          if (floor_ok && (pend & floor) != 4'd0) begin
            state     <= DWELL;
            door_open <= 1'b1;
            dcnt      <= DW_LAST;
            svc       <= floor;
          end
        end
        DWELL: begin
          if (floor != svc) begin
            // Car left (or floor reading is bad): abandon, keep the request.
            state     <= IDLE;
            door_open <= 1'b0;
          end else if ((rise & svc) != 4'd0) begin
            dcnt <= DW_LAST;
          end else if (dcnt == 16'd0) begin
            pend      <= pend_set & ~svc;
            door_open <= 1'b0;
            state     <= IDLE;
          end else begin
            dcnt <= dcnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/elevator_request_queue.md
ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a button level change is accepted (range 2..65535).
REQ-002 Parameter DWELL_CYCLES, default 8: door-open cycles at a served floor before its request is cleared (range 2..65535).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  raw, asynchronous call buttons; bit0=floor A ... bit3=floor D; active-high.
REQ-006 floor  input  4  one-hot current floor from the elevator controller; bit0=A ... bit3=D.
REQ-007 ra, rb, rc, rd  output  1 each  registered pending-request lines to the elevator controller for floors A..D.
REQ-008 pend  output  4  registered pending-request lamps; pend[i] equals the corresponding r* output.
REQ-009 door_open  output  1  registered; high while a dwell is in progress.
REQ-010 floor_err  output  1  registered sticky flag: a non-one-hot floor value was sampled.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per bit, a debounced level SHALL change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement resets that bit's counter to 0.
REQ-013 A 0->1 transition of a debounced level SHALL set pend[i] on the same edge the debounced level updates; 1->0 transitions have no effect on pend.
REQ-014 Latency: a clean press held steady SHALL set pend[i] exactly 2+DEBOUNCE_CYCLES clock edges after btn[i] rises (synchronizer plus debounce).
REQ-015 Pressing an already-pending floor SHALL leave pend unchanged (no toggling, no counting).
REQ-016 Control FSM states: IDLE, DWELL; reset state IDLE.
REQ-017 IDLE->DWELL when floor is one-hot and (pend & floor) != 0; on that edge: door_open<=1, dwell counter<=DWELL_CYCLES-1, serviced floor latched into an internal register.
REQ-018 In DWELL, the counter SHALL decrement by 1 per cycle; on the edge where it equals 0: pend bit of the serviced floor cleared, door_open<=0, state<=IDLE.
REQ-019 Door-open duration SHALL be exactly DWELL_CYCLES cycles when uninterrupted.
REQ-020 A new press edge for the serviced floor during DWELL SHALL reload the counter to DWELL_CYCLES-1 (door held open); pend stays 1.
REQ-021 Simultaneous expiry and press edge for the serviced floor: set wins; pend stays 1, counter reloads, state remains DWELL.
REQ-022 Press edges for other floors during DWELL SHALL set their pend bits normally and SHALL NOT affect the dwell.
REQ-023 If floor differs from the latched serviced floor while in DWELL: abort to IDLE, door_open<=0, serviced pend bit NOT cleared.
REQ-024 A non-one-hot floor (zero or multiple bits set) SHALL set floor_err, SHALL never start or complete a dwell, and in DWELL is treated as REQ-023.
REQ-025 Only one floor is serviced per dwell; no other pend bit is cleared by a dwell.
REQ-026 Counter widths SHALL be wide enough for the parameter maxima; no wrap-around is permitted.

Reset
REQ-027 While rst is low: pend=4'b0000, ra..rd=0, door_open=0, floor_err=0, FSM=IDLE, all synchronizer, debounced-level and counter registers 0.
REQ-028 Reset assertion mid-dwell or mid-debounce SHALL take effect immediately without waiting for clk; pending requests are discarded.
REQ-029 After rst deasserts, a button already held high SHALL register as a fresh press via REQ-012/REQ-013.

Verification
REQ-030 Defaults, floor=4'b0001, btn[2] held high from cycle 0 -> rc=1 and pend=4'b0100 at edge 18; door_open stays 0.
REQ-031 btn[1] pulse with 5-cycle glitch (<16) -> pend stays 4'b0000; btn[1] then held 20 cycles -> pend[1]=1.
REQ-032 pend=4'b0010, floor changes to 4'b0010 -> door_open=1 for exactly 8 cycles, then pend=4'b0000, state IDLE.
REQ-033 Dwell at floor B, btn[1] re-press edge lands on counter=0 cycle -> pend[1] stays 1, door_open stays 1 for a further 8 cycles.
REQ-034 Dwell at floor C, floor switches to 4'b1000 at cycle 3 of dwell -> door_open=0 next edge, pend[2] remains 1; floor=4'b0110 applied -> floor_err=1 until reset.
REQ-035 rst driven low mid-dwell with pend=4'b1011 -> pend=0, door_open=0, floor_err=0 asynchronously, before the next clk edge.
